sdr_burst_responder: RTL and testbench

- Memory-side responder for the cache refill/writeback bus.
- Receives a cache miss request on MStrobe/MRW/MAddr and answers with MGrant.
- Moves one cache line of BURST_COUNT words between the cache and a single-outstanding word memory port.
- Read bursts are delivered on mSDR_RxD; write bursts are collected on mSDR_TxD. Beats are always contiguous, so the cache's beat counter and 2-bit-per-beat RamWrite mask stay aligned.

---
 rtl/sdr_burst_responder_pkg.sv | 22 ++
 rtl/sdr_burst_responder_if.sv | 34 +++
 rtl/sdr_burst_responder_line_buf.sv | 25 ++
 rtl/sdr_burst_responder.sv | 172 +++++++++++++++++
 tb/tb_sdr_burst_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdr_burst_responder_pkg.sv
// Shared definitions for the SDR burst responder: FSM states, line size and timeout fill word.
package sdr_burst_responder_pkg;

  typedef enum logic [2:0] {
    RSP_IDLE,
    RSP_GRANT,
    RSP_FETCH,
    RSP_STREAM,
    RSP_COLLECT,
    RSP_STORE,
    RSP_DONE
  } rspState_e;

  localparam int SDR_BURST_COUNT = 4;
  localparam logic [31:0] FILL_WORD = 32'hDEAD_BEEF;

  // Address bits below a whole line: byte-in-word plus word-in-line.
  function automatic int lineOffsetBits(input int dataW, input int burst);
    return $clog2(dataW / 8) + $clog2(burst);
  endfunction

endpackage

// File: rtl/sdr_burst_responder_if.sv
// Cache refill/writeback bus plus the single-outstanding word memory port.
interface sdr_burst_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic              MGrant;
  logic              mSDR_RxD;
  logic              mSDR_TxD;
  logic [DATA_W-1:0] MDataOut;
  logic              MemReq;
  logic              MemWr;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] MemWData;
  logic              MemAck;
  logic [DATA_W-1:0] MemRData;
  logic              Error;

  // master: the cache and memory environment; slave: the responder itself.
  modport master (
    output MStrobe, MRW, MAddr, MDataIn, MemAck, MemRData,
    input  MGrant, mSDR_RxD, mSDR_TxD, MDataOut, MemReq, MemWr, MemAddr, MemWData, Error
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn, MemAck, MemRData,
    output MGrant, mSDR_RxD, mSDR_TxD, MDataOut, MemReq, MemWr, MemAddr, MemWData, Error
  );

endinterface

// File: rtl/sdr_burst_responder_line_buf.sv
// One cache line of storage: single write port, combinational read port.
module sdr_line_buf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic              Clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  wIdx_i,
  input  logic [DATA_W-1:0] wData_i,
  input  logic [IDX_W-1:0]  rIdx_i,
  output logic [DATA_W-1:0] rData_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[wIdx_i] <= wData_i;
    end
  end

  assign rData_o = mem_q[rIdx_i];

endmodule

// File: rtl/sdr_burst_responder.sv
// Memory-side responder moving one cache line between the cache bus and a word memory port.
// Optional MemAck timeout with DEADBEEF fill is enabled by defining SDR_RESP_TIMEOUT_EN.
module sdr_burst_responder
  import sdr_burst_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_COUNT = SDR_BURST_COUNT,
  parameter int TIMEOUT     = 64
) (
  input logic                  Clk,
  input logic                  Reset,
  sdr_burst_responder_if.slave bus
);

  localparam int IDX_W = $clog2(BURST_COUNT);
  localparam int OFF_W = lineOffsetBits(DATA_W, BURST_COUNT);
  localparam int BYTES = DATA_W / 8;

  rspState_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              isRead_q, isRead_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              abort_q, abort_d;

  logic              reqPhase;
  logic              timeoutHit;
  logic              lastBeat;
  logic              rxd;
  logic              txd;
  logic              bufWe;
  logic [DATA_W-1:0] bufWData;
  logic [DATA_W-1:0] bufRData;

  assign lastBeat = (idx_q == IDX_W'(BURST_COUNT - 1));
  assign reqPhase = ((state_q == RSP_FETCH) || (state_q == RSP_STORE)) && !abort_q;

  sdr_line_buf #(
    .DEPTH  (BURST_COUNT),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_lineBuf (
    .Clk     (Clk),
    .we_i    (bufWe),
    .wIdx_i  (idx_q),
    .wData_i (bufWData),
    .rIdx_i  (idx_q),
    .rData_o (bufRData)
  );

`ifdef SDR_RESP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] toCnt_q;
  logic            error_q;

  assign timeoutHit = reqPhase && !bus.MemAck && (toCnt_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      toCnt_q <= '0;
      error_q <= 1'b0;
    end else begin
      toCnt_q <= (reqPhase && !bus.MemAck) ? toCnt_q + TO_W'(1) : '0;
      if (timeoutHit) begin
        error_q <= 1'b1;
      end
    end
  end

  assign bus.Error = error_q;
`else
  logic unusedTimeout;

  assign unusedTimeout = ^TIMEOUT;
  assign timeoutHit    = 1'b0;
  assign bus.Error     = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= RSP_IDLE;
      base_q   <= '0;
      isRead_q <= 1'b0;
      idx_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      isRead_q <= isRead_d;
      idx_q    <= idx_d;
      abort_q  <= abort_d;
    end
  end

  // Every phase walks idx_q over the line; the last index hands off to the next phase.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    isRead_d = isRead_q;
    idx_d    = idx_q;
    abort_d  = abort_q;
    rxd      = 1'b0;
    txd      = 1'b0;
    bufWe    = 1'b0;
    bufWData = bus.MemRData;

    case (state_q)
      RSP_IDLE: begin
        if (bus.MStrobe) begin
          base_d   = {bus.MAddr[ADDR_W-1:OFF_W], OFF_W'(0)};
          isRead_d = bus.MRW;
          idx_d    = '0;
          abort_d  = 1'b0;
          state_d  = RSP_GRANT;
        end
      end
      RSP_GRANT: begin
        state_d = isRead_q ? RSP_FETCH : RSP_COLLECT;
      end
      RSP_FETCH: begin
        if (abort_q || bus.MemAck) begin
          bufWe    = 1'b1;
          bufWData = abort_q ? DATA_W'(FILL_WORD) : bus.MemRData;
          idx_d    = lastBeat ? '0 : idx_q + IDX_W'(1);
          state_d  = lastBeat ? RSP_STREAM : RSP_FETCH;
        end else if (timeoutHit) begin
          abort_d = 1'b1;
        end
      end
      RSP_STREAM: begin
        rxd     = 1'b1;
        idx_d   = lastBeat ? '0 : idx_q + IDX_W'(1);
        state_d = lastBeat ? RSP_DONE : RSP_STREAM;
      end
      RSP_COLLECT: begin
        txd      = 1'b1;
        bufWe    = 1'b1;
        bufWData = bus.MDataIn;
        idx_d    = lastBeat ? '0 : idx_q + IDX_W'(1);
        state_d  = lastBeat ? RSP_STORE : RSP_COLLECT;
      end
      RSP_STORE: begin
        if (abort_q) begin
          idx_d   = '0;
          state_d = RSP_DONE;
        end else if (bus.MemAck) begin
          idx_d   = lastBeat ? '0 : idx_q + IDX_W'(1);
          state_d = lastBeat ? RSP_DONE : RSP_STORE;
        end else if (timeoutHit) begin
          abort_d = 1'b1;
        end
      end
      RSP_DONE: begin
        state_d = RSP_IDLE;
      end
      default: begin
        state_d = RSP_IDLE;
      end
    endcase
  end

  assign bus.MGrant   = (state_q != RSP_IDLE);
  assign bus.mSDR_RxD = rxd;
  assign bus.mSDR_TxD = txd;
  assign bus.MDataOut = rxd ? bufRData : '0;
  assign bus.MemReq   = reqPhase;
  assign bus.MemWr    = reqPhase && !isRead_q;
  assign bus.MemAddr  = reqPhase ? base_q + (ADDR_W'(idx_q) * ADDR_W'(BYTES)) : '0;
  assign bus.MemWData = (reqPhase && !isRead_q) ? bufRData : '0;

endmodule

// File: tb/tb_sdr_burst_responder.sv
// Self-checking bench for sdr_burst_responder: a latency-programmable memory model plus
// a line-level expectation of what each refill/writeback must look like on both buses.
module tb_sdr_burst_responder;

  localparam int BC = 4;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          cyc;
  } memOp_t;

  logic Clk = 1'b0;
  logic Reset;
  int   cycleCount = 0;
  int   checkCount = 0;
  int   errorCount = 0;

  memOp_t      memLog[$];
  int          latTab [BC];
  logic [31:0] wdat [BC];
  bit          strayEn;

  sdr_burst_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sdr_burst_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .BURST_COUNT (BC),
    .TIMEOUT     (8)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cycleCount <= cycleCount + 1;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%h expected=%h at cycle %0d", tag, observed, expected, cycleCount);
    end
  endtask

  // Memory: acks the N-th request of a transaction after latTab[N] cycles (0 = never).
  bit     ackReal = 1'b0;
  int     reqAge = 0;
  int     curLat;
  memOp_t op;
  always @(negedge Clk) begin
    if (ackReal) reqAge = 0;
    ackReal      = 1'b0;
    bus.MemAck   = 1'b0;
    bus.MemRData = $urandom;
    if (bus.MemReq === 1'b1) begin
      reqAge++;
      curLat = (memLog.size() < BC) ? latTab[memLog.size()] : 1;
      if (curLat != 0 && reqAge >= curLat) begin
        bus.MemAck   = 1'b1;
        ackReal      = 1'b1;
        bus.MemRData = memModel(bus.MemAddr);
        op.addr  = bus.MemAddr;
        op.wr    = bus.MemWr;
        op.wdata = bus.MemWData;
        op.cyc   = cycleCount;
        memLog.push_back(op);
      end
    end else begin
      reqAge = 0;
      if (strayEn && $urandom_range(0, 3) == 0) bus.MemAck = 1'b1;
    end
  end

  task automatic applyStimulus(input logic rw, input logic [31:0] addr, input bit strobeInStream,
                               input bit expectTimeout);
    int          rxCyc[$];
    logic [31:0] rxDat[$];
    int          txCyc[$];
    int          t0, lastGrantCyc, errCyc, nOps, expCyc;
    logic        doneRx, doneTx;
    logic [31:0] base, expData;

    base   = addr & 32'hFFFF_FFF0;
    errCyc = -1;
    memLog.delete();
    @(negedge Clk);
    bus.MStrobe = 1'b1;
    bus.MRW     = rw;
    bus.MAddr   = addr;
    t0          = cycleCount;
    @(negedge Clk);
    bus.MStrobe = 1'b0;
    bus.MRW     = 1'($urandom);
    bus.MAddr   = $urandom;
    checkOutput("grantRise", bus.MGrant, 1);

    lastGrantCyc = cycleCount;
    doneRx = 1'b0;
    doneTx = 1'b0;
    for (int n = 0; n < 300 && bus.MGrant === 1'b1; n++) begin
      if (bus.mSDR_TxD === 1'b1) begin
        bus.MDataIn = (txCyc.size() < BC) ? wdat[txCyc.size()] : 32'h0;
        txCyc.push_back(cycleCount);
      end else begin
        bus.MDataIn = $urandom;
      end
      if (bus.mSDR_RxD === 1'b1) begin
        rxCyc.push_back(cycleCount);
        rxDat.push_back(bus.MDataOut);
      end
      if (bus.Error === 1'b1 && errCyc < 0) errCyc = cycleCount;
      bus.MStrobe  = strobeInStream && (bus.mSDR_RxD === 1'b1);
      doneRx       = bus.mSDR_RxD;
      doneTx       = bus.mSDR_TxD;
      lastGrantCyc = cycleCount;
      @(negedge Clk);
    end
    bus.MStrobe = 1'b0;

    checkOutput("grantFall", bus.MGrant, 0);
    checkOutput("doneRxLow", doneRx, 0);
    checkOutput("doneTxLow", doneTx, 0);

    nOps   = expectTimeout ? 2 : BC;
    expCyc = t0 + 1 + (rw ? 0 : BC);
    checkOutput("opCount", memLog.size(), nOps);
    for (int i = 0; i < nOps && i < memLog.size(); i++) begin
      expCyc += latTab[i];
      checkOutput("opAddr", memLog[i].addr, base + 32'(4 * i));
      checkOutput("opWr", memLog[i].wr, !rw);
      checkOutput("opCycle", memLog[i].cyc, expCyc);
      if (!rw) checkOutput("opWData", memLog[i].wdata, wdat[i]);
    end

    if (rw) begin
      checkOutput("rxBeats", rxCyc.size(), BC);
      checkOutput("txBeatsOnRead", txCyc.size(), 0);
      for (int i = 0; i < rxCyc.size() && i < BC; i++) begin
        expData = (i < nOps) ? memModel(base + 32'(4 * i)) : 32'hDEAD_BEEF;
        checkOutput("rxData", rxDat[i], expData);
        checkOutput("rxContig", rxCyc[i], rxCyc[0] + i);
      end
      if (!expectTimeout && rxCyc.size() > 0) checkOutput("rxStart", rxCyc[0], expCyc + 1);
      if (rxCyc.size() == BC) checkOutput("doneCycle", lastGrantCyc, rxCyc[BC-1] + 1);
    end else begin
      checkOutput("txBeats", txCyc.size(), BC);
      checkOutput("rxBeatsOnWrite", rxCyc.size(), 0);
      for (int i = 0; i < txCyc.size() && i < BC; i++) begin
        checkOutput("txCycle", txCyc[i], t0 + 2 + i);
      end
      checkOutput("doneCycle", lastGrantCyc, expCyc + 1);
    end

    if (expectTimeout) begin
      if (memLog.size() >= 2) checkOutput("errorCycle", errCyc, memLog[1].cyc + 1 + 8);
      checkOutput("errorSet", bus.Error, 1);
    end else begin
      checkOutput("errorLow", bus.Error, 0);
    end

    if (strobeInStream) begin
      @(negedge Clk);
      checkOutput("strayStrobeIgnored", bus.MGrant, 0);
    end
  endtask

  task automatic resetMidFetch();
    latTab = '{1, 1, 4, 4};
    memLog.delete();
    @(negedge Clk);
    bus.MStrobe = 1'b1;
    bus.MRW     = 1'b1;
    bus.MAddr   = 32'h0000_7770;
    @(negedge Clk);
    bus.MStrobe = 1'b0;
    for (int n = 0; n < 50 && memLog.size() < 2; n++) begin
      @(negedge Clk);
      #1;
    end
    checkOutput("twoAcksBeforeReset", memLog.size(), 2);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    checkOutput("rstGrant", bus.MGrant, 0);
    checkOutput("rstMemReq", bus.MemReq, 0);
    checkOutput("rstRxD", bus.mSDR_RxD, 0);
    Reset = 1'b0;
  endtask

  initial begin
    Reset       = 1'b1;
    bus.MStrobe = 1'b0;
    bus.MRW     = 1'b0;
    bus.MAddr   = '0;
    bus.MDataIn = '0;
    strayEn     = 1'b0;
    latTab      = '{1, 1, 1, 1};
    wdat        = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    repeat (3) @(negedge Clk);
    checkOutput("resetGrant", bus.MGrant, 0);
    checkOutput("resetRxD", bus.mSDR_RxD, 0);
    checkOutput("resetTxD", bus.mSDR_TxD, 0);
    checkOutput("resetDataOut", bus.MDataOut, 0);
    checkOutput("resetMemReq", bus.MemReq, 0);
    checkOutput("resetMemWr", bus.MemWr, 0);
    checkOutput("resetMemAddr", bus.MemAddr, 0);
    checkOutput("resetMemWData", bus.MemWData, 0);
    checkOutput("resetError", bus.Error, 0);
    Reset = 1'b0;
    @(negedge Clk);

    $display("[TB] read, single-cycle acks");
    applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0);

    $display("[TB] read, ack latencies 3 7 1 5");
    latTab = '{3, 7, 1, 5};
    applyStimulus(1'b1, 32'h00AB_CDE8, 1'b0, 1'b0);

    $display("[TB] write burst");
    latTab = '{2, 1, 3, 1};
    applyStimulus(1'b0, 32'h0000_8004, 1'b0, 1'b0);

    $display("[TB] strobe during stream, then back-to-back");
    latTab = '{1, 2, 1, 1};
    applyStimulus(1'b1, 32'h0000_2000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_3010, 1'b0, 1'b0);

    $display("[TB] reset mid-fetch");
    resetMidFetch();
    latTab = '{1, 1, 1, 1};
    applyStimulus(1'b1, 32'h0000_7770, 1'b0, 1'b0);

    $display("[TB] randomized transactions with stray acks");
    strayEn = 1'b1;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < BC; i++) begin
        latTab[i] = $urandom_range(1, 6);
        wdat[i]   = $urandom;
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef SDR_RESP_TIMEOUT_EN
    $display("[TB] timeout on word 2");
    latTab = '{1, 1, 0, 0};
    applyStimulus(1'b1, 32'h0000_4560, 1'b0, 1'b1);
    repeat (3) @(negedge Clk);
    checkOutput("errorSticky", bus.Error, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
